iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/iter_muldiv_if.sv | 36 +++
 rtl/iter_muldiv.sv | 180 ++++++++++++++++++
 tb/tb_iter_muldiv.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_if.sv
// Handshake and result bundle for the iterative multiply/divide unit.
// MULDIV_ABORT_EN adds an abort request line.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MULDIV_ABORT_EN
  logic             abort;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, a, b, abort,
    output busy, done, div_by_zero, hi, lo
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
`endif
endinterface

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiplier / restoring divider, one bit per cycle.
// Optional MULDIV_ABORT_EN lets CALC/FIX be cancelled via bus.abort.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  iter_muldiv_if.slave  bus
);
  localparam int CW = 7;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             isdiv_q, isdiv_d;
  logic             nega_q, nega_d;
  logic             negq_q, negq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   msum, dtrial;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign sgn   = ~bus.op[0];
  assign abs_a = (sgn && bus.a[WIDTH-1]) ?
                 (~bus.a + WIDTH'(1)) : bus.a;
  assign abs_b = (sgn && bus.b[WIDTH-1]) ?
                 (~bus.b + WIDTH'(1)) : bus.b;

  // Multiply: add multiplicand on LSB, then shift {rem,quot} right.
  // Divide: trial-subtract divisor from the shifted partial remainder.
  assign msum   = {1'b0, rem_q} +
                  (quot_q[0] ? {1'b0, opnd_q} : '0);
  assign dtrial = {rem_q, quot_q[WIDTH-1]} - {1'b0, opnd_q};

  assign prod   = {rem_q, quot_q};
  assign prod_n = ~prod + (2*WIDTH)'(1);
  assign q_fix  = negq_q ? (~quot_q + WIDTH'(1)) : quot_q;
  assign r_fix  = nega_q ? (~rem_q + WIDTH'(1)) : rem_q;

  // Next-state, datapath step and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isdiv_d = isdiv_q;
    nega_d  = nega_q;
    negq_d  = negq_q;
    opnd_d  = opnd_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          isdiv_d = bus.op[1];
          nega_d  = sgn & bus.a[WIDTH-1];
          negq_d  = sgn & (bus.a[WIDTH-1] ^
                           bus.b[WIDTH-1]);
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          if (bus.op[1]) begin
            opnd_d = abs_b;
            quot_d = abs_a;
          end else begin
            opnd_d = abs_a;
            quot_d = abs_b;
          end
          if (bus.op[1] && (bus.b == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (isdiv_q) begin
          if (!dtrial[WIDTH])
            rem_d = dtrial[WIDTH-1:0];
          else
            rem_d = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
          quot_d = {quot_q[WIDTH-2:0], ~dtrial[WIDTH]};
        end else begin
          rem_d  = msum[WIDTH:1];
          quot_d = {msum[0], quot_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1))
          state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (isdiv_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else if (negq_q) begin
          {hi_d, lo_d} = prod_n;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
`ifdef MULDIV_ABORT_EN
    if (bus.abort && busy_q) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
`endif
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      isdiv_q <= 1'b0;
      nega_q  <= 1'b0;
      negq_q  <= 1'b0;
      opnd_q  <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isdiv_q <= isdiv_d;
      nega_q  <= nega_d;
      negq_q  <= negq_d;
      opnd_q  <= opnd_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_iter_muldiv.sv
// Testbench for iter_muldiv at WIDTH=32: vector table, corner
// sequences and random ops against an arithmetic model.
module tb_iter_muldiv;
  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  iter_muldiv_if #(.WIDTH(W)) bus ();

  iter_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts one op and waits (bounded) for done, then returns to IDLE.
  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] hi,
                       output logic [31:0] lo,
                       output logic dbz,
                       output int lat,
                       output int bcyc,
                       output logic dbz_t1,
                       output logic ovl);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    cyc();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom);
    lat    = 1;
    bcyc   = 0;
    dbz_t1 = bus.div_by_zero;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcyc++;
      cyc();
      lat++;
    end
    if (!bus.done) lat = -1;
    ovl = bus.busy & bus.done;
    hi  = bus.hi;
    lo  = bus.lo;
    dbz = bus.div_by_zero;
    cyc();
  endtask

  // Reference arithmetic using 64-bit integers.
  function automatic void model(input logic [1:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] mhi,
                                inout logic [31:0] mlo,
                                output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    dbz = 1'b0;
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        {mhi, mlo} = p;
      end
      2'b01: begin
        p = ua * ub;
        {mhi, mlo} = p;
      end
      2'b10: begin
        if (b == 0) begin
          dbz = 1'b1;
        end else begin
          q = sa / sb;
          r = sa % sb;
          mlo = q[31:0];
          mhi = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          dbz = 1'b1;
        end else begin
          p = ua / ub;
          mlo = p[31:0];
          p = ua % ub;
          mhi = p[31:0];
        end
      end
    endcase
  endfunction

  logic [31:0] r_hi, r_lo, m_hi, m_lo;
  logic        r_dbz, r_dbz1, r_ovl, m_dbz;
  int          r_lat, r_bc;
  logic        seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MULDIV_ABORT_EN
    bus.abort = 1'b0;
`endif

    vecs[0] = '{"mult_neg", 2'b00, 32'hFFFFFFFD,
                32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34};
    vecs[1] = '{"multu_max", 2'b01, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0, 34};
    vecs[2] = '{"div_neg7_2", 2'b10, 32'hFFFFFFF9,
                32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34};
    vecs[3] = '{"div_ovf", 2'b10, 32'h80000000,
                32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34};
    vecs[4] = '{"mult_minmin", 2'b00, 32'h80000000,
                32'h80000000, 32'h40000000, 32'h0, 0, 34};
    vecs[5] = '{"div_7_neg2", 2'b10, 32'h7,
                32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 0, 34};
    vecs[6] = '{"divu_max_1", 2'b11, 32'hFFFFFFFF,
                32'h1, 32'h0, 32'hFFFFFFFF, 0, 34};
    vecs[7] = '{"divu_5_2", 2'b11, 32'h5,
                32'h2, 32'h1, 32'h2, 0, 34};
    vecs[8] = '{"divu_by0", 2'b11, 32'h10,
                32'h0, 32'h1, 32'h2, 1, 1};
    vecs[9] = '{"div_by0", 2'b10, 32'h3,
                32'h0, 32'h1, 32'h2, 1, 1};

    // Reset state
    cyc();
    cyc();
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_done", 64'(bus.done), 64'h0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'h0);
    reset = 1'b1;

    // Table vectors; first starts on the first edge after release
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b,
            r_hi, r_lo, r_dbz, r_lat, r_bc, r_dbz1, r_ovl);
      check({vecs[i].name, "_hi"}, 64'(r_hi), 64'(vecs[i].hi));
      check({vecs[i].name, "_lo"}, 64'(r_lo), 64'(vecs[i].lo));
      check({vecs[i].name, "_dbz"}, 64'(r_dbz),
            64'(vecs[i].dbz));
      check({vecs[i].name, "_lat"}, 64'(r_lat),
            64'(vecs[i].lat));
      check({vecs[i].name, "_busy"}, 64'(r_bc),
            vecs[i].dbz ? 64'd0 : 64'd33);
      check({vecs[i].name, "_ovl"}, 64'(r_ovl), 64'h0);
    end

    // Flag cleared one cycle after the next accepted start
    do_op(2'b01, 32'd5, 32'd6,
          r_hi, r_lo, r_dbz, r_lat, r_bc, r_dbz1, r_ovl);
    check("clr_dbz_t1", 64'(r_dbz1), 64'h0);
    check("clr_lo", 64'(r_lo), 64'h1E);
    check("clr_hi", 64'(r_hi), 64'h0);
    check("clr_lat", 64'(r_lat), 64'd34);

    // Random ops against the model
    m_hi = 32'h0;
    m_lo = 32'h1E;
    for (int i = 0; i < 80; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          k;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      k  = $urandom_range(0, 7);
      if (k == 0) b = '0;
      if (k == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if (k == 2) begin
        a = 32'($signed(8'($urandom)));
        b = 32'($signed(4'($urandom)));
      end
      model(op, a, b, m_hi, m_lo, m_dbz);
      do_op(op, a, b,
            r_hi, r_lo, r_dbz, r_lat, r_bc, r_dbz1, r_ovl);
      check($sformatf("rnd%0d_hi op%0d %h %h", i, op, a, b),
            64'(r_hi), 64'(m_hi));
      check($sformatf("rnd%0d_lo", i), 64'(r_lo), 64'(m_lo));
      check($sformatf("rnd%0d_dbz", i), 64'(r_dbz), 64'(m_dbz));
      check($sformatf("rnd%0d_lat", i), 64'(r_lat),
            m_dbz ? 64'd1 : 64'd34);
    end

    // Re-pulsed start ignored, reset abandons the op
    seen = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    cyc();
    for (int k = 1; k < 20; k++) begin
      bus.start = (k == 10);
      if (k == 10) begin
        bus.a = 32'd7;
        bus.b = 32'd9;
      end
      if (bus.done) seen = 1'b1;
      cyc();
    end
    bus.start = 1'b0;
    check("repulse_no_done", 64'(seen), 64'h0);
    reset = 1'b0;
    #1;
    check("arst_hi", 64'(bus.hi), 64'h0);
    check("arst_lo", 64'(bus.lo), 64'h0);
    check("arst_busy", 64'(bus.busy), 64'h0);
    check("arst_done", 64'(bus.done), 64'h0);
    check("arst_dbz", 64'(bus.div_by_zero), 64'h0);
    cyc();
    cyc();
    reset = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      cyc();
    end
    check("post_rst_idle", 64'(seen), 64'h0);
    do_op(2'b01, 32'd5, 32'd6,
          r_hi, r_lo, r_dbz, r_lat, r_bc, r_dbz1, r_ovl);
    check("post_rst_lo", 64'(r_lo), 64'h1E);
    check("post_rst_hi", 64'(r_hi), 64'h0);
    check("post_rst_lat", 64'(r_lat), 64'd34);

`ifdef MULDIV_ABORT_EN
    // Abort in CALC: idle next cycle, no done, results kept
    seen = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k < 5; k++) cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'h0);
    for (int k = 0; k < 40; k++) begin
      if (bus.done) seen = 1'b1;
      cyc();
    end
    check("abort_no_done", 64'(seen), 64'h0);
    check("abort_hi", 64'(bus.hi), 64'h0);
    check("abort_lo", 64'(bus.lo), 64'h1E);
    do_op(2'b11, 32'd100, 32'd7,
          r_hi, r_lo, r_dbz, r_lat, r_bc, r_dbz1, r_ovl);
    check("after_abort_lo", 64'(r_lo), 64'd14);
    check("after_abort_hi", 64'(r_hi), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
